// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the audio input and output blocks.
package i2s_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } rx_state_t;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

    localparam int unsigned DEFAULT_SAMPLE_WIDTH = 16;

endpackage

// File: rtl/i2s_sync.sv
// Two-flop synchroniser with a registered previous value for edge detection.
module i2s_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic s1;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            q    <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= d;
            q    <= s1;
            prev <= q;
        end
    end

    assign rise_c = q & ~prev;
    assign fall_c = ~q & prev;

endmodule

// File: rtl/i2s_audio_in.sv
// I2S slave receiver: oversamples bclk/lrclk/sdata in the clk domain and
// emits one stereo frame per valid pulse.
module i2s_audio_in
    import i2s_pkg::*;
#(
    parameter int unsigned clk_mhz      = 50,
    parameter int unsigned sample_width = DEFAULT_SAMPLE_WIDTH,
    parameter int unsigned max_slot     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bclk,
    input  logic                    lrclk,
    input  logic                    sdata,
    output logic [sample_width-1:0] left_out,
    output logic [sample_width-1:0] right_out,
    output logic                    valid,
    output logic                    short_slot
);

    localparam int unsigned W  = sample_width;
    localparam int unsigned CW = $clog2(max_slot + 1);

    logic bclk_q, bclk_rise_c, bclk_fall_c;
    logic lr_s, lr_rise_c, lr_fall_c;
    logic sd_s, sd_rise_c, sd_fall_c;

    i2s_sync u_sync_bclk (.clk(clk), .rst(rst), .d(bclk),  .q(bclk_q), .rise_c(bclk_rise_c), .fall_c(bclk_fall_c));
    i2s_sync u_sync_lr   (.clk(clk), .rst(rst), .d(lrclk), .q(lr_s),   .rise_c(lr_rise_c),   .fall_c(lr_fall_c));
    i2s_sync u_sync_sd   (.clk(clk), .rst(rst), .d(sdata), .q(sd_s),   .rise_c(sd_rise_c),   .fall_c(sd_fall_c));

    logic unused_edges;
    assign unused_edges = ^{lr_rise_c, lr_fall_c, sd_rise_c, sd_fall_c};

    rx_state_t       state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    sh;
    logic [W-1:0]    hold_left;
    logic            hold_short;
    logic            lr_prev;

    logic            transition_c;
    logic [W-1:0]    msb_bit_c;
    logic [W-1:0]    sh_next_c;
    logic [CW-1:0]   cnt_next_c;
    logic            slot_short_c;
    logic            commit_left_c;
    logic            commit_right_c;

    // The bit on the lrclk-change edge still belongs to the old slot (Philips timing).
    assign transition_c = bclk_rise_c && (lr_s != lr_prev);
    assign msb_bit_c    = {sd_s, {(W-1){1'b0}}};
    assign sh_next_c    = (32'(cnt) < W) ? (sh | (msb_bit_c >> cnt)) : sh;
    assign cnt_next_c   = (32'(cnt) >= max_slot) ? cnt : cnt + CW'(1);
    assign slot_short_c = 32'(cnt_next_c) < W;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        if (transition_c) begin
            case (state)
                SYNC:    if (lr_s == LR_LEFT)  state_nxt = LEFT;
                LEFT:    if (lr_s == LR_RIGHT) state_nxt = RIGHT;
                RIGHT:   if (lr_s == LR_LEFT)  state_nxt = LEFT;
                default: state_nxt = SYNC;
            endcase
        end
    end

    // Commit strobes.
    always_comb begin
        commit_left_c  = 1'b0;
        commit_right_c = 1'b0;
        if (transition_c) begin
            commit_left_c  = (state == LEFT)  && (lr_s == LR_RIGHT);
            commit_right_c = (state == RIGHT) && (lr_s == LR_LEFT);
        end
    end

    // Slot shifter/counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            sh         <= '0;
            lr_prev    <= 1'b0;
            hold_left  <= '0;
            hold_short <= 1'b0;
            left_out   <= '0;
            right_out  <= '0;
            valid      <= 1'b0;
            short_slot <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (bclk_rise_c) begin
                lr_prev <= lr_s;
                if (transition_c) begin
                    sh  <= '0;
                    cnt <= '0;
                end else begin
                    sh  <= sh_next_c;
                    cnt <= cnt_next_c;
                end
            end
            if (commit_left_c) begin
                hold_left  <= sh_next_c;
                hold_short <= slot_short_c;
            end
            if (commit_right_c) begin
                left_out   <= hold_left;
                right_out  <= sh_next_c;
                short_slot <= hold_short | slot_short_c;
                valid      <= 1'b1;
            end
        end
    end

    if (clk_mhz < 4) begin : g_clk_too_slow
        $fatal(1, "i2s_audio_in: clk_mhz too low for bclk oversampling");
    end

    // Each bclk phase must span at least two clk periods.
    a_bclk_high: assert property (@(posedge clk) disable iff (rst) bclk_rise_c |=> bclk_q);
    a_bclk_low:  assert property (@(posedge clk) disable iff (rst) bclk_fall_c |=> !bclk_q);

endmodule

// File: tb/tb_i2s_audio_in.sv
// Self-checking bench for i2s_audio_in: directed frame table, reset corners, random frames.
module tb_i2s_audio_in;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          bclk;
    logic          lrclk;
    logic          sdata;
    logic [W-1:0]  left_out;
    logic [W-1:0]  right_out;
    logic          valid;
    logic          short_slot;

    i2s_audio_in #(.clk_mhz(50), .sample_width(W), .max_slot(32)) dut (
        .clk(clk), .rst(rst), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .left_out(left_out), .right_out(right_out), .valid(valid), .short_slot(short_slot)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        logic         s;
    } obs_t;

    typedef struct {
        int           nl;
        int           nr;
        logic [63:0]  vl;
        logic [63:0]  vr;
        logic [W-1:0] el;
        logic [W-1:0] er;
        logic         es;
    } vec_t;

    obs_t obs_q[$];
    int   errors = 0;
    int   checks = 0;

    // Every valid-cycle snapshot; two-cycle pulses show up as extra entries.
    always @(negedge clk) begin
        if (valid) obs_q.push_back('{left_out, right_out, short_slot});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: slot value of n bits, MSB first, mapped to W bits.
    function automatic logic [W-1:0] model_word(input logic [63:0] v, input int n);
        logic [63:0] t;
        if (n >= W) t = v >> (n - W);
        else        t = v << (W - n);
        return t[W-1:0];
    endfunction

    task automatic drive_bit(input logic lr, input logic d, input int half);
        lrclk = lr;
        sdata = d;
        repeat (half) @(negedge clk);
        bclk = 1'b1;
        repeat (half) @(negedge clk);
        bclk = 1'b0;
    endtask

    // Philips framing: lrclk flips together with the LSB of the previous slot.
    task automatic send_frame(input int nl, input logic [63:0] vl, input int nr,
                              input logic [63:0] vr, input int half, input bit chk_lat);
        for (int k = nl - 1; k >= 1; k--) drive_bit(1'b0, vl[k], half);
        drive_bit(1'b1, vl[0], half);
        for (int k = nr - 1; k >= 1; k--) drive_bit(1'b1, vr[k], half);
        lrclk = 1'b0;
        sdata = vr[0];
        repeat (half) @(negedge clk);
        bclk = 1'b1;
        if (chk_lat) begin
            @(posedge clk); #1 check("latency_edge1", 64'(valid), 64'd0);
            @(posedge clk); #1 check("latency_edge2", 64'(valid), 64'd0);
            @(posedge clk); #1 check("latency_edge3", 64'(valid), 64'd1);
        end
        repeat (half) @(negedge clk);
        bclk = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_left"},  64'(left_out),   64'd0);
        check({tag, "_right"}, 64'(right_out),  64'd0);
        check({tag, "_valid"}, 64'(valid),      64'd0);
        check({tag, "_short"}, 64'(short_slot), 64'd0);
    endtask

    task automatic expect_frame(input string tag, input int base, input logic [W-1:0] el,
                                input logic [W-1:0] er, input logic es);
        check({tag, "_count"}, 64'(obs_q.size()), 64'(base + 1));
        if (obs_q.size() > base) begin
            check({tag, "_left"},  64'(obs_q[base].l), 64'(el));
            check({tag, "_right"}, 64'(obs_q[base].r), 64'(er));
            check({tag, "_short"}, 64'(obs_q[base].s), 64'(es));
        end
    endtask

    vec_t vecs[6];

    initial begin
        int base;
        int nl, nr, half;
        logic [63:0] vl, vr;

        vecs[0] = '{16, 16, 64'h1234,       64'hABCD,       16'h1234, 16'hABCD, 1'b0};
        vecs[1] = '{32, 32, 64'h89ABCD00,   64'h12345600,   16'h89AB, 16'h1234, 1'b0};
        vecs[2] = '{8,  8,  64'hA5,         64'h3C,         16'hA500, 16'h3C00, 1'b1};
        vecs[3] = '{40, 40, 64'hDEADBEEF12, 64'h0123456789, 16'hDEAD, 16'h0123, 1'b0};
        vecs[4] = '{16, 8,  64'hFFFF,       64'h81,         16'hFFFF, 16'h8100, 1'b1};
        vecs[5] = '{1,  17, 64'h1,          64'h1FFFF,      16'h8000, 16'hFFFF, 1'b1};

        rst = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;

        // Reset held while bclk toggles.
        for (int i = 0; i < 5; i++) begin
            repeat (2) @(negedge clk);
            bclk = ~bclk;
            sdata = ~sdata;
        end
        bclk = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_outputs_zero("reset");
        check("reset_no_valid", 64'(obs_q.size()), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // lrclk already low at release: this frame only synchronises.
        send_frame(16, 64'h1234, 16, 64'hABCD, 8, 1'b0);
        repeat (6) @(negedge clk);
        #1 check("unsynced_no_valid", 64'(obs_q.size()), 64'd0);

        for (int i = 0; i < 6; i++) begin
            base = obs_q.size();
            send_frame(vecs[i].nl, vecs[i].vl, vecs[i].nr, vecs[i].vr, 8, i == 0);
            repeat (6) @(negedge clk);
            #1 expect_frame($sformatf("vec%0d", i), base, vecs[i].el, vecs[i].er, vecs[i].es);
        end

        // Reset in the middle of a right slot.
        for (int k = 15; k >= 1; k--) drive_bit(1'b0, 1'b1, 8);
        drive_bit(1'b1, 1'b1, 8);
        for (int k = 0; k < 8; k++) drive_bit(1'b1, 1'b1, 8);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 check_outputs_zero("midreset");
        base = obs_q.size();
        for (int k = 0; k < 7; k++) drive_bit(1'b1, 1'b0, 8);
        drive_bit(1'b0, 1'b0, 8);
        repeat (6) @(negedge clk);
        #1 check("midreset_no_valid", 64'(obs_q.size()), 64'(base));
        for (int f = 0; f < 3; f++) begin
            send_frame(16, 64'h1111, 16, 64'h2222, 8, 1'b0);
            repeat (6) @(negedge clk);
            #1 expect_frame($sformatf("resync%0d", f), base + f, 16'h1111, 16'h2222, 1'b0);
        end

        // Random frames against the arithmetic model.
        base = obs_q.size();
        for (int f = 0; f < 100; f++) begin
            int b;
            nl   = int'($urandom_range(1, 34));
            nr   = int'($urandom_range(1, 34));
            vl   = {$urandom, $urandom};
            vr   = {$urandom, $urandom};
            half = int'($urandom_range(3, 5));
            b    = obs_q.size();
            send_frame(nl, vl, nr, vr, half, 1'b0);
            repeat (5) @(negedge clk);
            #1 expect_frame($sformatf("rand%0d", f), b, model_word(vl, nl), model_word(vr, nr),
                            (nl < W) || (nr < W));
        end
        check("rand_total_pulses", 64'(obs_q.size() - base), 64'd100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_audio_in.md
# i2s_audio_in

I2S slave receiver that deserialises a stereo stream from an external codec/ADC (codec drives bclk, lrclk, sdata) into parallel left/right samples in the clk domain. It is the input-side counterpart of i2s_audio_out in the guitar processing chain: its samples feed the effects pipeline, whose result goes to i2s_audio_out. All I2S inputs are asynchronous to clk; they are oversampled and synchronised internally.

## Interface
- clk_mhz, 50, system clock frequency in MHz; informational, used only for assertions (bclk must stay below clk_mhz/4 MHz).
- sample_width, 16, output sample width W; matches the DAC resolution used by i2s_audio_out.
- max_slot, 32, saturation limit of the per-slot bit counter; slots longer than this are still accepted.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset: rst, synchronous, active-high; clock clk.
- bclk  in  1  I2S bit clock from codec, asynchronous.
- lrclk  in  1  I2S word select, asynchronous; 0 = left, 1 = right.
- sdata  in  1  I2S serial data, MSB first, asynchronous.
- left_out  out  W  last complete left sample.
- right_out  out  W  last complete right sample.
- valid  out  1  one-cycle pulse; left_out/right_out hold a new frame.
- short_slot  out  1  qualifies valid; 1 if either slot of that frame had fewer than W bits.

## Operation
- bclk, lrclk and sdata each pass through an identical 2-FF synchroniser. A bclk rising edge is detected when the synchronised bclk is 1 and its previous registered value is 0. lrclk and sdata are sampled on that same clk cycle.
- Philips I2S timing: lrclk changes one bclk before the MSB. The bit sampled on the edge where lrclk differs from the previous sampled lrclk is the LSB of the old slot.
- Per slot: bit counter cnt (0..max_slot, saturating) and shift register sh[W-1:0].
  - Non-transition edge: if cnt < W, then sh[W-1-cnt] <= sdata. cnt increments (saturating).
  - Transition edge: store the bit by the same rule, then commit sh for the old channel. Bits not received stay 0, so a short slot is zero-padded LSBs. Bits beyond W are dropped, so a long slot is truncated to its upper W bits.
  - After a commit, sh clears and cnt clears for the new slot.
- State machine:
  - SYNC: entered on reset. Data is ignored. On the first transition to lrclk=0, go to LEFT.
  - LEFT: on a transition to 1, commit left into a holding register and go to RIGHT.
  - RIGHT: on a transition to 0, commit right, drive left_out from the holding register, pulse valid, and go to LEFT.
- short_slot is computed from the final cnt of both slots (final cnt < W for either) and is registered with valid.
- Outputs hold their values between valid pulses.

## Timing
- Reset values:
  - left_out = 0, right_out = 0, valid = 0, short_slot = 0.
  - state = SYNC, cnt = 0, sh = 0, holding register = 0.
  - Synchroniser flops reset to 0.
- Latency: valid rises on the 3rd clk edge after the first clk edge that samples raw bclk high at the right-to-left transition. The stages are sync1, sync2/edge detect, and output register.
- valid is high for exactly 1 clk. There is at most one pulse per frame and no backpressure; the consumer must take the data in that cycle.
- Input constraint: bclk high and low phases are each ≥ 2 clk periods.
- Reset mid-frame: all outputs return to their reset values. No valid is issued until a full left+right frame has been received after the next lrclk 1→0 transition.
- lrclk already 0 at reset release: no transition occurs, so the machine stays in SYNC until the next 1→0 transition.
- Slot with 0 data bits (lrclk toggles on consecutive edges): that slot commits as the single transition bit in the MSB position, with short_slot = 1.

## Structure
- Package i2s_pkg, shared with i2s_audio_out:
  - rx_state_t enum {SYNC, LEFT, RIGHT}.
  - Constants LR_LEFT = 0 and LR_RIGHT = 1.
  - Default sample width constant of 16.
- Sub-module i2s_sync: 2-FF synchroniser with a registered previous value and rise/fall outputs. It is instantiated three times, and its rise output is used for bclk.
- Everything else (counter, shifter, FSM, output registers) lives in i2s_audio_in.

## Test plan
- Reset held 10 cycles while bclk toggles → all outputs 0, valid never asserts.
- 16-bit slots, left = 0x1234, right = 0xABCD, bclk = 3.125 MHz → after the first full frame, valid pulses once, left_out = 0x1234, right_out = 0xABCD, short_slot = 0.
- 32-bit slots carrying 24-bit left = 0x89ABCD and right = 0x123456 → left_out = 0x89AB, right_out = 0x1234, short_slot = 0.
- 8-bit slots, left = 0xA5, right = 0x3C → left_out = 0xA500, right_out = 0x3C00, short_slot = 1.
- Reset asserted mid-right-slot, then three frames of 0x1111/0x2222 → no valid until one full frame after the first 1→0 transition, then 0x1111/0x2222.
- 100 back-to-back random frames → exactly 100 valid pulses (after sync), each spaced one frame apart, each with correct data.
